// File: rtl/seq_restoring_divider32_if.sv
// Handshake bundle for seq_restoring_divider32.
//   Request side : in_valid / in_ready, dividend, divisor
//   Response side: out_valid / out_ready, quotient, remainder, div_by_zero
// The master modport is the client that issues divisions and consumes results.
// The slave modport is the divider itself.
interface seq_restoring_divider32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider32.sv
// Multi-cycle unsigned 32-bit restoring divider, one quotient bit per clock.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; aborts any division in flight
//   bus    - slave side of seq_restoring_divider32_if
//            in_valid/in_ready   : accept N (dividend) and D (divisor), in_ready only in IDLE
//            out_valid/out_ready : quotient, remainder, div_by_zero, out_valid only in DONE
// A 32-bit ripple-carry adder computing S + ~D + 1 serves as the trial subtractor;
// its carry-out of 1 means "no borrow", i.e. S >= D.

// 32-bit ripple-carry adder used as the trial subtractor.
module RippleCarryAdder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[32];
endmodule

module seq_restoring_divider32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_restoring_divider32_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;         // partial remainder
  logic [WIDTH-1:0]   q_q, q_d;         // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dreg_q, dreg_d;   // captured divisor
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  // One restoring step: shift the next dividend bit into the remainder, then
  // try subtracting the divisor.
  logic               msb;
  logic [WIDTH-1:0]   s_shift;
  logic [WIDTH-1:0]   t_diff;
  logic               co;
  logic               ok;
  logic [WIDTH-1:0]   r_step;
  logic [WIDTH-1:0]   q_step;

  assign msb     = r_q[WIDTH-1];
  assign s_shift = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  RippleCarryAdder32 u_trial_sub (
    .a    (s_shift),
    .b    (~dreg_q),
    .cin  (1'b1),
    .sum  (t_diff),
    .cout (co)
  );

  // A set msb means the real shifted remainder is 2^32 + S, which always
  // exceeds D; the wrapped difference is still the correct remainder.
  assign ok     = msb | co;
  assign r_step = ok ? t_diff : s_shift;
  assign q_step = {q_q[WIDTH-2:0], ok};

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    dreg_d      = dreg_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          q_d    = bus.dividend;
          dreg_d = bus.divisor;
          r_d    = '0;
          cnt_d  = '0;
          if (bus.divisor == '0) begin
            // Divide-by-zero skips the iterations and reports all-ones / N.
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quotient_d  = q_step;
          remainder_d = r_step;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      dreg_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dreg_q      <= dreg_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
